alu_arbiter: RTL

Shares the single combinational RV32 ALU between two requesters, e.g. the execute stage and the address/branch-compare path.
- Arbitrates requests round-robin.
- Drives the ALU operands and control code for the winner.
- Captures the ALU result in a one-entry output buffer with a valid/ready response handshake.
- Sits between the requesters and the existing alu instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// The ALU result is captured in a one-entry response buffer with a valid/ready handshake.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [OP_W-1:0]  req0_alu_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [OP_W-1:0]  req1_alu_op,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [OP_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // reqN_ready is combinational and never asserted without reqN_valid; rsp_valid stays
  // high with stable payload until rsp_ready is seen.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [OP_W-1:0] IDLE_CTRL = OP_W'(4'b0010);

  state_t state, state_next;
  logic   last_grant;
  logic   can_issue;
  logic   sel_valid;
  logic   sel_id;
  logic   grant;
  logic   sel_legal;

  function automatic logic is_legal(input logic [OP_W-1:0] code);
    logic ok;
    case (code)
      OP_W'(4'b0000), OP_W'(4'b0001), OP_W'(4'b0010), OP_W'(4'b0110),
      OP_W'(4'b0100), OP_W'(4'b0101), OP_W'(4'b1000), OP_W'(4'b1001),
      OP_W'(4'b1010): ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Selection ignores backpressure so the ALU always sees the pending winner's operands.
  always_comb begin
    sel_valid = req0_valid | req1_valid;
    sel_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_id = ~last_grant;
    end else if (req1_valid) begin
      sel_id = 1'b1;
    end
  end

  always_comb begin
    can_issue = (state == EMPTY) || rsp_ready;
    grant     = rst && sel_valid && can_issue;
    req0_ready = grant && (sel_id == 1'b0);
    req1_ready = grant && (sel_id == 1'b1);
  end

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = IDLE_CTRL;
    if (rst && sel_valid) begin
      if (sel_id) begin
        alu_op1  = req1_op1;
        alu_op2  = req1_op2;
        alu_ctrl = req1_alu_op;
      end else begin
        alu_op1  = req0_op1;
        alu_op2  = req0_op2;
        alu_ctrl = req0_alu_op;
      end
    end
  end

  assign sel_legal = is_legal(alu_ctrl);

  always_comb begin
    state_next = state;
    if (grant) begin
      state_next = FULL;
    end else if (state == FULL && rsp_ready) begin
      state_next = EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        last_grant <= sel_id;
        rsp_id     <= sel_id;
        // Illegal codes are still consumed; the ALU output is meaningless, so report zeros.
        rsp_result <= sel_legal ? alu_result : '0;
        rsp_zero   <= sel_legal ? alu_zero : 1'b0;
        rsp_err    <= ~sel_legal;
      end
    end
  end

endmodule
